// File: rtl/pe_out_collector.sv
// Collects PE-array output frames, buffers them and writes enabled lanes to data memory.
// Optional PE_OUT_DROPCNT_EN adds a saturating dropped-frame counter output (drop_cnt).
module pe_out_collector #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 12,
  parameter int unsigned DLY    = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADR_W  = 10,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADR_W-1:0]        base_adr,
  input  logic [CNT_W-1:0]        frame_cnt,
  input  logic [LANES-1:0]        lane_mask,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_we,
  output logic [ADR_W-1:0]        out_adr,
  output logic [DATA_W-1:0]       out_wd,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
`ifdef PE_OUT_DROPCNT_EN
  output logic [7:0]              drop_cnt,
`endif
  output logic                    overflow
);

  localparam int unsigned FW = LANES * DATA_W;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FullCnt = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Alignment delay line
  logic          cap_v;
  logic [FW-1:0] cap_data;

  if (DLY == 0) begin : g_direct
    assign cap_v    = in_valid;
    assign cap_data = in_data;
  end else begin : g_dly
    logic [DLY-1:0]    v_q;
    logic [DLY*FW-1:0] d_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
      end else begin
        v_q <= DLY'({v_q, in_valid});
      end
    end

    always_ff @(posedge clk) begin
      d_q <= (DLY*FW)'({d_q, in_data});
    end

    assign cap_v    = v_q[DLY-1];
    assign cap_data = d_q[DLY*FW-1 -: FW];
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   left_q, left_d;
  logic [FW-1:0]      mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [PW:0]        count_q, count_d;
  logic [LANES-1:0]   sent_q, sent_d;
  logic [LANES-1:0]   mask_q;
  logic [ADR_W-1:0]   wr_adr_q;
  logic               done_q, done_d;
  logic               ovf_q;

  logic               empty, full, push, pop, drop, latch;
  logic [FW-1:0]      head;
  logic [LANES-1:0]   pending, cur_oh;
  logic               last_lane, wr_fire;
  logic [DATA_W-1:0]  lane_wd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCnt);
  assign head  = mem_q[rd_ptr_q];

  // Lanes of the head frame still to be written; lowest one is emitted next.
  assign pending   = empty ? '0 : (mask_q & ~sent_q);
  assign cur_oh    = pending & (~pending + 1'b1);
  assign last_lane = ((pending & ~cur_oh) == '0);
  assign wr_fire   = out_we & out_ready;
  assign pop       = !empty && ((pending == '0) || (wr_fire && last_lane));

  always_comb begin
    lane_wd = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cur_oh[i]) lane_wd = head[i*DATA_W +: DATA_W];
    end
  end

  assign push = (state_q == StRun) && cap_v && (!full || pop);
  assign drop = (state_q == StRun) && cap_v && !push;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    sent_d = sent_q;
    if (pop)          sent_d = '0;
    else if (wr_fire) sent_d = sent_q | cur_oh;
  end

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    done_d  = 1'b0;
    latch   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          latch = 1'b1;
          if (frame_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
            left_d  = frame_cnt;
          end
        end
      end
      StRun: begin
        // Dropped frames count too, so the block always terminates.
        if (cap_v) begin
          left_d = left_q - 1'b1;
          if (left_q == CNT_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (count_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cap_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      left_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      mask_q   <= '0;
      wr_adr_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      done_q  <= done_d;
      count_q <= count_d;
      sent_q  <= sent_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (latch) begin
        mask_q   <= lane_mask;
        wr_adr_q <= base_adr;
        ovf_q    <= 1'b0;
      end else begin
        if (wr_fire) wr_adr_q <= wr_adr_q + 1'b1;
        if (drop)    ovf_q    <= 1'b1;
      end
    end
  end

`ifdef PE_OUT_DROPCNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || latch) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_we   = (pending != '0);
  assign out_adr  = wr_adr_q;
  assign out_wd   = out_we ? lane_wd : '0;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
